wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Write-side master for the register file's single write port.
//  Merges two writeback sources: the in-order pipeline WB stage (never stalls) and a multi-cycle unit (valid/ready).
//  Multi-cycle results are buffered in a small FIFO. A per-register pending scoreboard feeds ID-stage hazard logic.
//  Drives WB_en/WB_dest/WB_result from posedge registers; the register file commits them on the following negedge.
// PARAMETERS
//  WORD_WIDTH  `WORD_WIDTH (32)      data width of a writeback
//  DEST_WIDTH  `REG_FILE_DEPTH (4)   register index width
//  NUM_REGS    `REG_FILE_SIZE (16)   registers tracked by the scoreboard
//  FIFO_DEPTH  2                     multi-cycle result buffer entries; power of two, >=2
// PORTS
//  clk             in   1           system clock, posedge
//  rst             in   1           reset, asynchronous, active-high
//  pipe_wb_en      in   1           pipeline writeback valid; always accepted
//  pipe_wb_dest    in   DEST_WIDTH  pipeline destination register
//  pipe_wb_result  in   WORD_WIDTH  pipeline writeback data
//  mc_issue        in   1           multi-cycle op issued this cycle; marks issue_dest pending
//  mc_issue_dest   in   DEST_WIDTH  destination of the issued multi-cycle op
//  mc_valid        in   1           multi-cycle result available
//  mc_ready        out  1           arbiter accepts a result this cycle
//  mc_dest         in   DEST_WIDTH  multi-cycle result destination
//  mc_result       in   WORD_WIDTH  multi-cycle result data
//  WB_en           out  1           register file write enable, registered
//  WB_dest         out  DEST_WIDTH  register file write index, registered
//  WB_result       out  WORD_WIDTH  register file write data, registered
//  pending         out  NUM_REGS    bit r=1: register r awaits a multi-cycle writeback
//  sb_err          out  1           1-cycle pulse on a scoreboard protocol violation
// BEHAVIOUR
//  Reset: WB_en=0, WB_dest=0, WB_result=0, FIFO empty, pending=0, sb_err=0; mc_ready=1 once count=0.
//  Reset mid-operation drops all buffered results and pending bits.
//  Handshake: transfer on mc_valid&&mc_ready.
//   - mc_ready = (count != FIFO_DEPTH), taken from the registered count only.
//   - mc_ready stays 0 when full, even if a pop occurs in the same cycle.
//   - No combinational path from mc_valid to mc_ready.
//  Select each cycle, priority order:
//   (1) pipe_wb_en=1: WB_* <= pipe_* next edge; FIFO holds its entry.
//   (2) else FIFO non-empty: WB_* <= head; pop.
//   (3) else WB_en <= 0; WB_dest/WB_result hold their last value.
//  Latency:
//   - Pipeline write: 1 cycle (sampled edge N, WB_en high in cycle N+1).
//   - Multi-cycle write: accepted cycle N, earliest WB_en in cycle N+2. A push never bypasses to the output.
//  Push and pop in the same cycle: count unchanged; FIFO order preserved; pointers wrap modulo FIFO_DEPTH.
//  Scoreboard:
//   - pending[mc_issue_dest] set at the edge after mc_issue.
//   - pending[d] cleared at the edge the FIFO pop drives WB_dest=d.
//   - Issue and clear of the same register in one cycle: set wins.
//  sb_err pulses (registered) when:
//   - mc_issue targets an already-pending register;
//   - an accepted mc_dest is not pending;
//   - pipe_wb_en targets a pending register.
//   The write itself still proceeds, and pending is unaffected by pipeline writes.
//  Starvation: continuous pipe_wb_en starves the FIFO. This is legal; the producer sees mc_ready=0 once full.
// STRUCTURE
//  Widths come from the `WORD_WIDTH/`REG_FILE_DEPTH/`REG_FILE_SIZE defines in settings.h.
//  Add `WB_FIFO_DEPTH there.
//  Sub-module wb_fifo: synchronous FIFO, {dest,result} payload, count output, async rst.
//  Arbiter select, output registers and scoreboard live in the top module.
// TESTING
//  1. Reset mid-stream with 2 entries buffered and pending=16'h0006 -> WB_en=0, pending=0, mc_ready=1 immediately.
//  2. pipe_wb_en dest=3 data=32'hDEAD_BEEF, single cycle -> WB_en=1, WB_dest=3, WB_result=32'hDEADBEEF next cycle only.
//  3. mc_issue dest=5; 4 cycles later mc_valid dest=5 data=7, no pipe traffic:
//     -> pending[5]=1 from issue+1; WB_en with dest=5 two cycles after accept; pending[5]=0 on that same edge.
//  4. pipe_wb_en held 4 cycles while mc_valid presents 3 results (dests 1,2,4 pending):
//     -> 2 accepted, then mc_ready=0; after pipe stops, writes 1,2 retire in order, then 4 is accepted and written.
//  5. mc_issue dest=5 while pending[5]=1 -> sb_err pulse 1 cycle; pipe_wb_en to pending reg 2 -> sb_err pulse, WB write still occurs.
//  6. FIFO full, pop and mc_valid in the same cycle -> mc_ready=0 that cycle, 1 next cycle; no data lost or reordered.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths and types for the register-file write arbiter.
// The defaults below apply when settings.h has not already defined the widths.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 16
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 2
`endif

package wb_write_arbiter_pkg;

  localparam int WORD_WIDTH = `WORD_WIDTH;
  localparam int DEST_WIDTH = `REG_FILE_DEPTH;
  localparam int NUM_REGS   = `REG_FILE_SIZE;
  localparam int FIFO_DEPTH = `WB_FIFO_DEPTH;

  // Which source drives the write port in the current cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Synchronous FIFO for multi-cycle writeback results ({dest,result} payload).
// Power-of-two depth, so pointers wrap naturally; head is the oldest entry.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port master: merges the never-stalling pipeline WB stage
// with buffered multi-cycle results, and tracks per-register pending writes.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = wb_write_arbiter_pkg::WORD_WIDTH,
  parameter int DEST_WIDTH = wb_write_arbiter_pkg::DEST_WIDTH,
  parameter int NUM_REGS   = wb_write_arbiter_pkg::NUM_REGS,
  parameter int FIFO_DEPTH = wb_write_arbiter_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wb_en,
  input  logic [DEST_WIDTH-1:0] pipe_wb_dest,
  input  logic [WORD_WIDTH-1:0] pipe_wb_result,
  input  logic                  mc_issue,
  input  logic [DEST_WIDTH-1:0] mc_issue_dest,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [DEST_WIDTH-1:0] mc_dest,
  input  logic [WORD_WIDTH-1:0] mc_result,
  output logic                  WB_en,
  output logic [DEST_WIDTH-1:0] WB_dest,
  output logic [WORD_WIDTH-1:0] WB_result,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  sb_err
);

  localparam int CNT_W   = count_width(FIFO_DEPTH);
  localparam int ENTRY_W = DEST_WIDTH + WORD_WIDTH;

  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [DEST_WIDTH-1:0] head_dest;
  logic [WORD_WIDTH-1:0] head_result;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_sel_e               wb_sel;
  logic [NUM_REGS-1:0]   pending_next;
  logic                  sb_err_next;

  // Handshake: a result transfers on mc_valid && mc_ready. mc_ready depends only
  // on the registered FIFO count, so it stays low while full even if the FIFO
  // drains in the same cycle, and mc_valid never feeds back into it.
  assign mc_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push = mc_valid && mc_ready;

  assign head_dest   = fifo_head[ENTRY_W-1:WORD_WIDTH];
  assign head_result = fifo_head[WORD_WIDTH-1:0];

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({mc_dest, mc_result}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    wb_sel = SEL_IDLE;
    if (pipe_wb_en) begin
      wb_sel = SEL_PIPE;
    end else if (fifo_count != '0) begin
      wb_sel = SEL_FIFO;
    end
  end

  assign fifo_pop = (wb_sel == SEL_FIFO);

  // A retiring multi-cycle write clears its bit; a same-cycle issue re-sets it.
  always_comb begin
    pending_next = pending;
    if (fifo_pop) begin
      pending_next[head_dest] = 1'b0;
    end
    if (mc_issue) begin
      pending_next[mc_issue_dest] = 1'b1;
    end
  end

  assign sb_err_next = (mc_issue && pending[mc_issue_dest])
                    || (fifo_push && !pending[mc_dest])
                    || (pipe_wb_en && pending[pipe_wb_dest]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_en     <= 1'b0;
      WB_dest   <= '0;
      WB_result <= '0;
      pending   <= '0;
      sb_err    <= 1'b0;
    end else begin
      pending <= pending_next;
      sb_err  <= sb_err_next;
      case (wb_sel)
        SEL_PIPE: begin
          WB_en     <= 1'b1;
          WB_dest   <= pipe_wb_dest;
          WB_result <= pipe_wb_result;
        end
        SEL_FIFO: begin
          WB_en     <= 1'b1;
          WB_dest   <= head_dest;
          WB_result <= head_result;
        end
        default: begin
          WB_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized + directed bench for wb_write_arbiter against a queue-based model.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        pipe_wb_en;
  logic [3:0]  pipe_wb_dest;
  logic [31:0] pipe_wb_result;
  logic        mc_issue;
  logic [3:0]  mc_issue_dest;
  logic        mc_valid;
  logic        mc_ready;
  logic [3:0]  mc_dest;
  logic [31:0] mc_result;
  logic        WB_en;
  logic [3:0]  WB_dest;
  logic [31:0] WB_result;
  logic [15:0] pending;
  logic        sb_err;

  typedef struct packed {
    logic        en;
    logic [3:0]  dest;
    logic [31:0] res;
    logic [15:0] pend;
    logic        err;
    logic        rdy;
  } st_t;

  logic [35:0] exp_q[$];
  st_t         st_q[$];
  logic [35:0] mq[$];
  logic [15:0] mpend;
  logic [3:0]  last_d;
  logic [31:0] last_r;
  int          n_cmp;
  int          n_err;
  st_t         s;
  logic [35:0] e;

  wb_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_wb_en     (pipe_wb_en),
    .pipe_wb_dest   (pipe_wb_dest),
    .pipe_wb_result (pipe_wb_result),
    .mc_issue       (mc_issue),
    .mc_issue_dest  (mc_issue_dest),
    .mc_valid       (mc_valid),
    .mc_ready       (mc_ready),
    .mc_dest        (mc_dest),
    .mc_result      (mc_result),
    .WB_en          (WB_en),
    .WB_dest        (WB_dest),
    .WB_result      (WB_result),
    .pending        (pending),
    .sb_err         (sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus; the model advances to the state after the next posedge.
  task automatic step(input logic p_en, input logic [3:0] p_d, input logic [31:0] p_r,
                      input logic iss, input logic [3:0] i_d,
                      input logic v, input logic [3:0] m_d, input logic [31:0] m_r,
                      output logic acc);
    logic        en;
    logic        err;
    logic [35:0] ent;
    @(negedge clk);
    #1;
    pipe_wb_en = p_en; pipe_wb_dest = p_d; pipe_wb_result = p_r;
    mc_issue = iss; mc_issue_dest = i_d;
    mc_valid = v; mc_dest = m_d; mc_result = m_r;
    acc = v && (mq.size() < FIFO_DEPTH);
    err = (iss && mpend[i_d]) || (acc && !mpend[m_d]) || (p_en && mpend[p_d]);
    en = 1'b0;
    if (p_en) begin
      en = 1'b1; last_d = p_d; last_r = p_r;
    end else if (mq.size() > 0) begin
      ent = mq.pop_front();
      en = 1'b1; last_d = ent[35:32]; last_r = ent[31:0];
      mpend[last_d] = 1'b0;
    end
    if (en) exp_q.push_back({last_d, last_r});
    if (acc) mq.push_back({m_d, m_r});
    if (iss) mpend[i_d] = 1'b1;
    st_q.push_back('{en, last_d, last_r, mpend, err, (mq.size() < FIFO_DEPTH)});
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    pipe_wb_en = 0; mc_issue = 0; mc_valid = 0;
    rst = 1'b1;
    #1;
    check("rst_wb_en", 64'(WB_en), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_mc_ready", 64'(mc_ready), 64'd1);
    check("rst_sb_err", 64'(sb_err), 64'd0);
    mq.delete(); exp_q.delete(); st_q.delete();
    mpend = '0; last_d = '0; last_r = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: status every cycle, write payloads whenever WB_en is presented.
  always @(negedge clk) begin
    if (!rst && st_q.size() > 0) begin
      s = st_q.pop_front();
      check("wb_en", 64'(WB_en), 64'(s.en));
      check("wb_dest", 64'(WB_dest), 64'(s.dest));
      check("wb_result", 64'(WB_result), 64'(s.res));
      check("pending", 64'(pending), 64'(s.pend));
      check("sb_err", 64'(sb_err), 64'(s.err));
      check("mc_ready", 64'(mc_ready), 64'(s.rdy));
      if (WB_en) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(WB_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_payload", 64'({WB_dest, WB_result}), 64'(e));
        end
      end
    end
  end

  initial begin
    logic        a;
    logic [3:0]  items[$];
    logic [3:0]  d;
    logic [3:0]  cand[$];
    n_cmp = 0; n_err = 0;
    mpend = '0; last_d = '0; last_r = '0;
    pipe_wb_en = 0; pipe_wb_dest = 0; pipe_wb_result = 0;
    mc_issue = 0; mc_issue_dest = 0; mc_valid = 0; mc_dest = 0; mc_result = 0;
    rst = 1'b1;
    #2;
    check("init_wb_en", 64'(WB_en), 64'd0);
    check("init_wb_dest", 64'(WB_dest), 64'd0);
    check("init_wb_result", 64'(WB_result), 64'd0);
    check("init_pending", 64'(pending), 64'd0);
    check("init_mc_ready", 64'(mc_ready), 64'd1);
    #10 rst = 1'b0;

    // Two buffered results with pending = regs 1,2, then reset mid-stream.
    step(0, 0, 0, 1, 1, 0, 0, 0, a);
    step(0, 0, 0, 1, 2, 0, 0, 0, a);
    step(1, 8, 32'h11, 0, 0, 1, 1, 32'hA1, a);
    step(1, 9, 32'h12, 0, 0, 1, 2, 32'hA2, a);
    @(posedge clk);
    #1;
    check("pre_rst_pending", 64'(pending), 64'h0006);
    check("pre_rst_full", 64'(mc_ready), 64'd0);
    do_reset();

    // Single pipeline write.
    step(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, a);
    idle(2);

    // Issue, later result, retirement clears pending.
    step(0, 0, 0, 1, 5, 0, 0, 0, a);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 5, 32'd7, a);
    idle(3);

    // Pipeline starves the FIFO while three results queue up.
    step(0, 0, 0, 1, 1, 0, 0, 0, a);
    step(0, 0, 0, 1, 2, 0, 0, 0, a);
    step(0, 0, 0, 1, 4, 0, 0, 0, a);
    items = '{4'd1, 4'd2, 4'd4};
    for (int i = 0; i < 4; i++) begin
      step(1, 4'(8 + i), $urandom, 0, 0, items.size() > 0, items.size() > 0 ? items[0] : 4'd0,
           32'h100 + 32'(i), a);
      if (a) void'(items.pop_front());
    end
    for (int i = 0; i < 8 && items.size() > 0; i++) begin
      step(0, 0, 0, 0, 0, 1, items[0], 32'h200 + 32'(i), a);
      if (a) void'(items.pop_front());
    end
    idle(3);

    // Scoreboard violations: double issue and pipeline write to a pending reg.
    step(0, 0, 0, 1, 5, 0, 0, 0, a);
    step(0, 0, 0, 1, 5, 0, 0, 0, a);
    step(0, 0, 0, 1, 2, 0, 0, 0, a);
    step(1, 2, 32'hCAFE_0002, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 1, 5, 32'h55, a);
    step(0, 0, 0, 0, 0, 1, 2, 32'h22, a);
    idle(3);

    // Random traffic; results mostly target pending registers.
    for (int i = 0; i < 1500; i++) begin
      cand.delete();
      for (int r = 0; r < 16; r++) if (mpend[r]) cand.push_back(4'(r));
      if (cand.size() > 0 && $urandom_range(0, 9) < 8)
        d = cand[$urandom_range(0, cand.size() - 1)];
      else
        d = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 5, d, $urandom, a);
      if (i == 700) do_reset();
    end
    idle(6);
    @(negedge clk);
    #2;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("model_fifo_drained", 64'(mq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
